// File: rtl/axil_led_pattern_gpio_if.sv
// AXI4-Lite channel bundle for the LED pattern GPIO (5-bit byte address, 32-bit data).
interface axil_led_pattern_gpio_if;
   logic [4:0]  S_AXI_AWADDR;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [4:0]  S_AXI_ARADDR;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/axil_led_pattern_gpio.sv
// AXI4-Lite LED GPIO: per-channel static / blink / PWM / off, with a shared
// blink prescaler and a global 8-bit PWM duty.
module axil_led_pattern_gpio #(
   parameter int          NUM_CH       = 4,
   parameter logic [31:0] PRESCALE_RST = 32'd24_999_999,
   parameter logic [7:0]  DUTY_RST     = 8'h80
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   axil_led_pattern_gpio_if.slave  s_axi,
   output logic [NUM_CH-1:0]       led_o
);
   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [NUM_CH-1:0]   data_r;
   logic [2*NUM_CH-1:0] mode_r;
   logic [31:0]         prescale_r;
   logic [7:0]          duty_r;

   logic [31:0] presc_cnt;
   logic        phase;
   logic [7:0]  pwm_cnt;
   logic        pwm_on;
   logic [NUM_CH-1:0] led_nxt;

   w_state_t    w_state, w_next;
   logic        aw_held, w_held;
   logic [2:0]  aw_idx_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [1:0]  bresp_q;
   logic        aw_rdy, w_rdy, aw_hs, w_hs, wr_fire, wr_ok, presc_wr;
   logic [2:0]  wr_idx;
   logic [31:0] wr_data, wr_old, wr_new;
   logic [3:0]  wr_strb;

   r_state_t    r_state, r_next;
   logic        ar_rdy, ar_hs;
   logic [31:0] rdata_q, rd_data;
   logic [1:0]  rresp_q, rd_resp;

   // Byte-lane merge of a write beat into the current register contents.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   // ---------------- write channel ----------------
   assign aw_rdy  = !ARESET && (w_state == W_IDLE) && !aw_held;
   assign w_rdy   = !ARESET && (w_state == W_IDLE) && !w_held;
   assign aw_hs   = s_axi.S_AXI_AWVALID && aw_rdy;
   assign w_hs    = s_axi.S_AXI_WVALID && w_rdy;

   // A beat captured earlier takes precedence over the live bus value.
   assign wr_idx  = aw_held ? aw_idx_q : s_axi.S_AXI_AWADDR[4:2];
   assign wr_data = w_held  ? wdata_q  : s_axi.S_AXI_WDATA;
   assign wr_strb = w_held  ? wstrb_q  : s_axi.S_AXI_WSTRB;
   assign wr_ok   = (wr_idx < 3'd4);
   assign presc_wr = wr_fire && (wr_idx == 3'd2);

   assign s_axi.S_AXI_AWREADY = aw_rdy;
   assign s_axi.S_AXI_WREADY  = w_rdy;
   assign s_axi.S_AXI_BVALID  = (w_state == W_RESP);
   assign s_axi.S_AXI_BRESP   = bresp_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   always_comb begin
      w_next  = w_state;
      wr_fire = 1'b0;
      case (w_state)
         W_IDLE: begin
            if ((aw_held || aw_hs) && (w_held || w_hs)) begin
               wr_fire = 1'b1;
               w_next  = W_RESP;
            end
         end
         W_RESP:  if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
      end else if (wr_fire) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_idx_q <= s_axi.S_AXI_AWADDR[4:2];
         end
         if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= s_axi.S_AXI_WDATA;
            wstrb_q <= s_axi.S_AXI_WSTRB;
         end
      end
   end

   // ---------------- register file ----------------
   always_comb begin
      wr_old = '0;
      case (wr_idx)
         3'd0:    wr_old = 32'(data_r);
         3'd1:    wr_old = 32'(mode_r);
         3'd2:    wr_old = prescale_r;
         3'd3:    wr_old = 32'(duty_r);
         default: wr_old = '0;
      endcase
      wr_new = merge(wr_old, wr_data, wr_strb);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         data_r     <= '0;
         mode_r     <= '0;
         prescale_r <= PRESCALE_RST;
         duty_r     <= DUTY_RST;
      end else if (wr_fire) begin
         case (wr_idx)
            3'd0:    data_r     <= wr_new[NUM_CH-1:0];
            3'd1:    mode_r     <= wr_new[2*NUM_CH-1:0];
            3'd2:    prescale_r <= wr_new;
            3'd3:    duty_r     <= wr_new[7:0];
            default: ;
         endcase
      end
   end

   // ---------------- read channel ----------------
   assign ar_rdy = !ARESET && (r_state == R_IDLE);
   assign ar_hs  = s_axi.S_AXI_ARVALID && ar_rdy;

   assign s_axi.S_AXI_ARREADY = ar_rdy;
   assign s_axi.S_AXI_RVALID  = (r_state == R_DATA);
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_DATA;
         R_DATA:  if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (s_axi.S_AXI_ARADDR[4:2])
         3'd0:    rd_data = 32'(data_r);
         3'd1:    rd_data = 32'(mode_r);
         3'd2:    rd_data = prescale_r;
         3'd3:    rd_data = 32'(duty_r);
         3'd4:    rd_data = 32'(led_o);
         default: rd_resp = RESP_SLVERR;
      endcase
   end

   // Snapshot taken at the AR handshake, so same-cycle writes are not visible.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_hs) begin
         rdata_q <= rd_data;
         rresp_q <= rd_resp;
      end
   end

   // ---------------- timebases and LED drive ----------------
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         presc_cnt <= '0;
         phase     <= 1'b0;
         pwm_cnt   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (presc_wr) begin
            presc_cnt <= '0;
            phase     <= 1'b0;
         end else if (presc_cnt == prescale_r) begin
            presc_cnt <= '0;
            phase     <= ~phase;
         end else begin
            presc_cnt <= presc_cnt + 32'd1;
         end
      end
   end

   assign pwm_on = (pwm_cnt < duty_r);

   always_comb begin
      led_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (mode_r[2*i +: 2])
            2'b00:   led_nxt[i] = data_r[i];
            2'b01:   led_nxt[i] = data_r[i] & phase;
            2'b10:   led_nxt[i] = data_r[i] & pwm_on;
            default: led_nxt[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) led_o <= '0;
      else        led_o <= led_nxt;
   end

   wire unused_addr_lsbs = &{1'b0, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: doc/axil_led_pattern_gpio.md
Name: axil_led_pattern_gpio

Overview:
- AXI4-Lite slave driving NUM_CH LED outputs; generalises the fixed 4-bit LED GPIO behind the PS GP port.
- Per-channel mode: static, blink (programmable prescaler) or PWM (global 8-bit duty).
- Sits in the PL block design at the GPIO slot (base 0xA000_0000). The CPU and the PS VIP write_data/read_data tasks drive it.

Parameters:
- NUM_CH, 4, number of LED channels (1..16).
- PRESCALE_RST, 32'd24_999_999, reset value of PRESCALE register.
- DUTY_RST, 8'h80, reset value of DUTY register.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  5  write address (byte, word-aligned; bits[1:0] ignored).
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read handshake.
- led_o  out  NUM_CH  LED drive, registered.

Behaviour:
- Register map:
  - 0x00 DATA[NUM_CH-1:0] RW.
  - 0x04 MODE[2*NUM_CH-1:0] RW, 2 bits per channel: 00 static, 01 blink, 10 PWM, 11 off.
  - 0x08 PRESCALE[31:0] RW.
  - 0x0C DUTY[7:0] RW.
  - 0x10 LED_STATUS RO: current led_o.
  - Unimplemented register bits read 0.
- Reset (ARESET=1 at edge):
  - DATA=0, MODE=0, PRESCALE=PRESCALE_RST, DUTY=DUTY_RST.
  - Prescale counter=0, blink phase=0, PWM counter=0, led_o=0.
  - All VALIDs 0; AWREADY=WREADY=ARREADY=0 during reset and 1 the cycle after.
  - Reset mid-transaction drops the transaction; no BVALID/RVALID is produced for it.
- Write path, state machine W_IDLE -> W_RESP:
  - AW and W are accepted independently; each READY deasserts once its beat is captured.
  - When both are held, the register update happens in that cycle, WSTRB-masked per byte; BVALID asserts the next cycle.
  - Same-cycle AW+W gives BVALID at T+1.
  - BVALID holds until BREADY. AW/WREADY re-assert the cycle after the B handshake.
  - Address > 0x10, or a write to 0x10: no register change, BRESP=SLVERR.
  - Only one outstanding write at a time.
- Read path, state machine R_IDLE -> R_DATA:
  - ARREADY=1 in R_IDLE. On AR handshake at T, RDATA/RRESP are registered and RVALID=1 at T+1.
  - RVALID holds, RDATA stable, until RREADY. ARREADY re-asserts the following cycle.
  - Address > 0x10: RDATA=0, RRESP=SLVERR.
  - Reads and writes proceed concurrently. A read of a register written in the same cycle returns the old value.
- Blink timebase:
  - 32-bit counter increments each cycle.
  - When count==PRESCALE: counter goes to 0 and phase toggles, so phase period = 2*(PRESCALE+1) cycles.
  - PRESCALE=0 toggles phase every cycle.
  - Any write to PRESCALE clears counter and phase in the update cycle.
- PWM:
  - 8-bit free-running counter wraps 255 -> 0; pwm_on = (cnt < DUTY).
  - DUTY=0 gives always off; DUTY=255 gives on 255 of 256 cycles.
- Output per channel i, registered, 1-cycle latency from register/phase change:
  - 00 -> DATA[i]
  - 01 -> DATA[i] & phase
  - 10 -> DATA[i] & pwm_on
  - 11 -> 0

Test Plan:
- Reset then write 0x00 = 0xFFFFFFFF, MODE=0 -> led_o=4'hF one cycle after the W handshake; read 0x00 returns 0x0000000F with OKAY; read 0x10 returns 0xF.
- PRESCALE=3, MODE=0x55, DATA=0xF -> led_o toggles 0x0/0xF every 4 cycles (period 8); rewriting PRESCALE restarts the phase at 0.
- DUTY=0x40, MODE=0xAA, DATA=0x5 -> over 256 cycles led_o=0x5 for exactly 64 cycles; DUTY=0 gives a constant 0.
- W beat 3 cycles before AW, with BREADY held low 5 cycles -> BVALID asserts the cycle after AW is captured and holds stable; single register update; next write accepted only after the B handshake.
- Write to 0x14 and to 0x10 -> BRESP=SLVERR, no register change; read 0x18 -> RDATA=0, RRESP=SLVERR.
- ARESET pulsed while RVALID=1 and RREADY=0 -> RVALID=0, led_o=0, registers at reset values; the next read of 0x08 returns PRESCALE_RST.
